// File: rtl/sm_pkg.sv
// Shared constants and helpers for the pipelined sign-magnitude adder/subtractor.
// Payload structs depend on WIDTH/TAG_W, so they are declared inside the top module.
package sm_pkg;

  localparam logic SYM_ADD = 1'b0;
  localparam logic SYM_SUB = 1'b1;

  // An effective subtract happens when A and the effective sign of B differ.
  function automatic logic eff_sub(input logic sign_a, input logic sign_b, input logic symbol);
    return sign_a ^ (sign_b ^ (symbol == SYM_SUB));
  endfunction

endpackage

// File: rtl/sm_mag_cmp.sv
// Magnitude comparator with swap: the larger operand is always presented first.
module sm_mag_cmp #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ge,
  output logic             eq,
  output logic [WIDTH-1:0] big_mag,
  output logic [WIDTH-1:0] small_mag
);

  always_comb begin
    ge        = (a >= b);
    eq        = (a == b);
    big_mag   = ge ? a : b;
    small_mag = ge ? b : a;
  end

endmodule

// File: rtl/sm_addsub_pipe.sv
// Three-stage sign-magnitude adder/subtractor with valid/ready flow control.
// S1 resolves signs and orders operands, S2 does the add/subtract, S3 drives the outputs.
module sm_addsub_pipe
  import sm_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic             symbol,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             sign_out,
  output logic             zero,
  output logic             carry,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic             sub;
    logic             sign;
    logic [WIDTH-1:0] big_mag;
    logic [WIDTH-1:0] small_mag;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [WIDTH:0]   sum;
    logic [TAG_W-1:0] tag;
  } s2_t;

  logic             v1, v2;
  logic             ld1, ld2, ld3;
  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic             ge, eq;
  logic [WIDTH-1:0] big_mag, small_mag;

  // Each stage refills whenever it is empty or its successor is taking its beat.
  assign ld3      = !out_valid || out_ready;
  assign ld2      = !v2 || ld3;
  assign ld1      = !v1 || ld2;
  assign in_ready = ld1;

  sm_mag_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a         (a),
    .b         (b),
    .ge        (ge),
    .eq        (eq),
    .big_mag   (big_mag),
    .small_mag (small_mag)
  );

  // A zero difference is forced to +0; otherwise the larger magnitude's sign wins.
  always_comb begin
    s1_d           = '0;
    s1_d.sub       = eff_sub(sign_a, sign_b, symbol);
    s1_d.big_mag   = big_mag;
    s1_d.small_mag = small_mag;
    s1_d.tag       = in_tag;
    if (!s1_d.sub)
      s1_d.sign = sign_a;
    else if (eq)
      s1_d.sign = 1'b0;
    else
      s1_d.sign = ge ? sign_a : (sign_b ^ symbol);
  end

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.tag  = s1_q.tag;
    if (s1_q.sub)
      s2_d.sum = {1'b0, s1_q.big_mag} - {1'b0, s1_q.small_mag};
    else
      s2_d.sum = {1'b0, s1_q.big_mag} + {1'b0, s1_q.small_mag};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      out       <= '0;
      sign_out  <= 1'b0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (ld1) begin
        v1 <= in_valid;
        if (in_valid)
          s1_q <= s1_d;
      end
      if (ld2) begin
        v2 <= v1;
        if (v1)
          s2_q <= s2_d;
      end
      if (ld3) begin
        out_valid <= v2;
        if (v2) begin
          out      <= s2_q.sum;
          sign_out <= s2_q.sign;
          zero     <= (s2_q.sum == '0);
          carry    <= s2_q.sum[WIDTH];
          out_tag  <= s2_q.tag;
        end
      end
    end
  end

endmodule
